// File: rtl/poly_mult_sched_if.sv
// rtl/poly_mult_sched_if.sv - requester, multiplier and result-stream signals of the shared multiplier scheduler
interface poly_mult_sched_if #(
  parameter int RAMWIDTH       = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int LOG_MAX_WEIGHT = 7
);
  logic [1:0]                req;
  logic [LOG_MAX_WEIGHT-1:0] weight_0;
  logic [LOG_MAX_WEIGHT-1:0] weight_1;
  logic [1:0]                grant;
  logic                      sel;
  logic                      mult_start;
  logic [LOG_MAX_WEIGHT-1:0] mult_weight;
  logic                      mult_valid;
  logic                      mult_rd_dout;
  logic [ADDR_WIDTH-1:0]     mult_addr_result;
  logic [RAMWIDTH-1:0]       mult_dout;
  logic [RAMWIDTH-1:0]       out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic [1:0]                done;
  logic                      timeout_err;

  modport master (
    input  req, weight_0, weight_1, mult_valid, mult_dout, out_ready,
    output grant, sel, mult_start, mult_weight, mult_rd_dout, mult_addr_result,
           out_data, out_valid, out_last, done, timeout_err
  );

  modport slave (
    output req, weight_0, weight_1, mult_valid, mult_dout, out_ready,
    input  grant, sel, mult_start, mult_weight, mult_rd_dout, mult_addr_result,
           out_data, out_valid, out_last, done, timeout_err
  );
endinterface

// File: rtl/poly_mult_sched.sv
// rtl/poly_mult_sched.sv - round-robin owner of one sparse-dense multiplier with watchdog and result streaming
module poly_mult_sched #(
  parameter int RAMWIDTH       = 64,
  parameter int N              = 17669,
  parameter int RES_WORDS      = (N + RAMWIDTH - 1) / RAMWIDTH,
  parameter int ADDR_WIDTH     = 10,
  parameter int LOG_MAX_WEIGHT = 7,
  parameter int TIMEOUT        = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  poly_mult_sched_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_RADDR, S_RDATA, S_HOLD
  } state_t;

  state_t                    r_state, w_state;
  logic                      r_ptr, w_ptr;
  logic [1:0]                r_grant, w_grant;
  logic                      r_sel, w_sel;
  logic [LOG_MAX_WEIGHT-1:0] r_weight, w_weight;
  logic [WD_W-1:0]           r_wd, w_wd;
  logic [ADDR_WIDTH-1:0]     r_k, w_k;
  logic                      r_rd, w_rd;
  logic [RAMWIDTH-1:0]       r_data, w_data;
  logic                      r_valid, w_valid;
  logic                      r_last, w_last;
  logic [1:0]                r_done, w_done;
  logic                      r_terr, w_terr;
  logic [1:0]                w_pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_grant  <= '0;
      r_sel    <= 1'b0;
      r_weight <= '0;
      r_wd     <= '0;
      r_k      <= '0;
      r_rd     <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ptr    <= w_ptr;
      r_grant  <= w_grant;
      r_sel    <= w_sel;
      r_weight <= w_weight;
      r_wd     <= w_wd;
      r_k      <= w_k;
      r_rd     <= w_rd;
      r_data   <= w_data;
      r_valid  <= w_valid;
      r_last   <= w_last;
      r_done   <= w_done;
      r_terr   <= w_terr;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_grant  = r_grant;
    w_sel    = r_sel;
    w_weight = r_weight;
    w_wd     = r_wd;
    w_k      = r_k;
    w_rd     = r_rd;
    w_data   = r_data;
    w_valid  = r_valid;
    w_last   = r_last;
    w_done   = 2'b00;
    w_terr   = r_terr;
    w_pick   = bus.req;

    case (r_state)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          // The pointer moves only when both requesters compete.
          if (bus.req == 2'b11) begin
            w_pick = r_ptr ? 2'b10 : 2'b01;
            w_ptr  = ~r_ptr;
          end
          w_grant  = w_pick;
          w_sel    = w_pick[1];
          w_weight = w_pick[1] ? bus.weight_1 : bus.weight_0;
          w_state  = S_START;
        end
      end
      S_START: begin
        w_wd    = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        w_wd = r_wd + WD_W'(1);
        // r_wd==0 marks the first wait cycle, where valid may still be left over from the last job.
        if ((r_wd != '0) && bus.mult_valid) begin
          w_k     = '0;
          w_rd    = 1'b1;
          w_state = S_RADDR;
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_terr  = 1'b1;
          w_done  = r_grant;
          w_grant = 2'b00;
          w_state = S_IDLE;
        end
      end
      S_RADDR: begin
        w_state = S_RDATA;
      end
      S_RDATA: begin
        w_data  = bus.mult_dout;
        w_valid = 1'b1;
        w_last  = (r_k == ADDR_WIDTH'(RES_WORDS - 1));
        w_state = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_valid = 1'b0;
          w_last  = 1'b0;
          if (r_last) begin
            w_rd    = 1'b0;
            w_done  = r_grant;
            w_grant = 2'b00;
            w_state = S_IDLE;
          end else begin
            w_k     = r_k + ADDR_WIDTH'(1);
            w_state = S_RADDR;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.grant            = r_grant;
  assign bus.sel              = r_sel;
  assign bus.mult_start       = (r_state == S_START);
  assign bus.mult_weight      = r_weight;
  assign bus.mult_rd_dout     = r_rd;
  assign bus.mult_addr_result = r_k;
  assign bus.out_data         = r_data;
  assign bus.out_valid        = r_valid;
  assign bus.out_last         = r_last;
  assign bus.done             = r_done;
  assign bus.timeout_err      = r_terr;
endmodule

// File: tb/tb_poly_mult_sched.sv
// tb/tb_poly_mult_sched.sv - scoreboard bench for poly_mult_sched with a behavioural multiplier
module tb_poly_mult_sched;
  localparam int RAMWIDTH   = 64;
  localparam int N          = 17669;
  localparam int RES_WORDS  = 277;
  localparam int ADDR_WIDTH = 10;
  localparam int LMW        = 7;
  localparam int TIMEOUT    = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_mult_sched_if #(.RAMWIDTH(RAMWIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LOG_MAX_WEIGHT(LMW)) bus ();

  poly_mult_sched #(
    .RAMWIDTH(RAMWIDTH), .N(N), .RES_WORDS(RES_WORDS), .ADDR_WIDTH(ADDR_WIDTH),
    .LOG_MAX_WEIGHT(LMW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: valid rises lat cycles after start (lat=0 means never);
  // each result word carries the start count and its address.
  int         lat        = 20;
  bit         stale_mode = 1'b0;
  int         cnt        = 0;
  bit         stale_hold = 1'b0;
  logic [7:0] start_cnt  = 8'd0;
  logic       m_valid    = 1'b0;
  logic [63:0] m_dout    = 64'd0;
  assign bus.mult_valid = m_valid;
  assign bus.mult_dout  = m_dout;

  always @(posedge clk) begin
    if (bus.mult_start) begin
      cnt       <= lat - 1;
      start_cnt <= start_cnt + 8'd1;
      if (stale_mode) stale_hold <= 1'b1;
      else            m_valid    <= 1'b0;
    end else begin
      if (stale_hold) begin
        m_valid    <= 1'b0;
        stale_hold <= 1'b0;
      end
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) m_valid <= 1'b1;
      end
    end
    if (bus.mult_rd_dout)
      m_dout <= {24'hC0FFEE, start_cnt, 22'd0, bus.mult_addr_result};
  end

  bit rnd_ready = 1'b0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  typedef struct packed { logic [63:0] data; logic last; } word_t;
  typedef struct packed { logic [1:0] grant; logic sel; logic [LMW-1:0] weight; } job_t;
  word_t word_q[$];
  job_t  start_q[$];
  job_t  done_q[$];
  int    jobs = 0;
  int    hs_cnt = 0;

  // Monitor: pops expectations on every handshake, start and done; also checks hold stability.
  initial begin
    bit          hold_pend;
    logic [63:0] hold_data;
    logic        hold_last;
    word_t       w;
    job_t        j;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", 64'(bus.out_valid), 64'd1);
          chk("hold_data", bus.out_data, hold_data);
          chk("hold_last", 64'(bus.out_last), 64'(hold_last));
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_last = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
          hs_cnt++;
          chk("word_expected", 64'(word_q.size() > 0), 64'd1);
          if (word_q.size() > 0) begin
            w = word_q.pop_front();
            chk("word_data", bus.out_data, w.data);
            chk("word_last", 64'(bus.out_last), 64'(w.last));
          end
        end
        if (bus.mult_start) begin
          chk("start_expected", 64'(start_q.size() > 0), 64'd1);
          if (start_q.size() > 0) begin
            j = start_q.pop_front();
            chk("start_grant", 64'(bus.grant), 64'(j.grant));
            chk("start_sel", 64'(bus.sel), 64'(j.sel));
            chk("start_weight", 64'(bus.mult_weight), 64'(j.weight));
          end
        end
        if (bus.done != 2'b00) begin
          chk("done_expected", 64'(done_q.size() > 0), 64'd1);
          if (done_q.size() > 0) begin
            j = done_q.pop_front();
            chk("done_owner", 64'(bus.done), 64'(j.grant));
            chk("done_sel", 64'(bus.sel), 64'(j.sel));
            chk("done_weight", 64'(bus.mult_weight), 64'(j.weight));
            chk("grant_after_done", 64'(bus.grant), 64'd0);
          end
        end
      end
    end
  end

  task automatic push_job(input logic [1:0] g, input logic [LMW-1:0] wt, input bit with_words);
    job_t  j;
    word_t w;
    logic [9:0] a10;
    jobs++;
    j.grant = g; j.sel = g[1]; j.weight = wt;
    start_q.push_back(j);
    done_q.push_back(j);
    if (with_words) begin
      for (int a = 0; a < RES_WORDS; a++) begin
        a10    = 10'(a);
        w.data = {24'hC0FFEE, 8'(jobs), 22'd0, a10};
        w.last = (a == RES_WORDS - 1);
        word_q.push_back(w);
      end
    end
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mult_start;
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.done != 2'b00);
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_grant"}, 64'(bus.grant), 64'd0);
    chk({name, "_sel"}, 64'(bus.sel), 64'd0);
    chk({name, "_start"}, 64'(bus.mult_start), 64'd0);
    chk({name, "_weight"}, 64'(bus.mult_weight), 64'd0);
    chk({name, "_rd"}, 64'(bus.mult_rd_dout), 64'd0);
    chk({name, "_addr"}, 64'(bus.mult_addr_result), 64'd0);
    chk({name, "_data"}, bus.out_data, 64'd0);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_last"}, 64'(bus.out_last), 64'd0);
    chk({name, "_done"}, 64'(bus.done), 64'd0);
    chk({name, "_terr"}, 64'(bus.timeout_err), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int c;
    int hs0;
    bus.req = 2'b00; bus.weight_0 = '0; bus.weight_1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single requester, slow multiplier; weight change after grant must not matter.
    lat = 500;
    push_job(2'b01, 7'd66, 1'b1);
    bus.weight_0 = 7'd66; bus.req = 2'b01;
    wait_start("t1_start");
    bus.req = 2'b00; bus.weight_0 = 7'd99;
    c = 0;
    while (!bus.out_valid && c < 2000) begin @(negedge clk); c++; end
    chk("t1_first_word_latency", 64'(c), 64'd503);
    wait_done("t1_done");
    @(negedge clk);
    chk("t1_grant_idle", 64'(bus.grant), 64'd0);

    // Both requesting for four jobs: 0,1,0,1.
    lat = 20;
    bus.weight_0 = 7'd11; bus.weight_1 = 7'd22;
    push_job(2'b01, 7'd11, 1'b1);
    push_job(2'b10, 7'd22, 1'b1);
    push_job(2'b01, 7'd11, 1'b1);
    push_job(2'b10, 7'd22, 1'b1);
    bus.req = 2'b11;
    for (int i = 0; i < 4; i++) wait_start("t2_start");
    bus.req = 2'b00;
    wait_done("t2_done");

    // Random backpressure.
    rnd_ready = 1'b1;
    bus.weight_1 = 7'd5;
    push_job(2'b10, 7'd5, 1'b1);
    bus.req = 2'b10;
    wait_start("t3_start");
    bus.req = 2'b00;
    hs0 = hs_cnt;
    wait_done("t3_done");
    chk("t3_handshakes", 64'(hs_cnt - hs0), 64'(RES_WORDS));
    rnd_ready = 1'b0;

    // Valid still high from the previous job during the first wait cycle.
    stale_mode = 1'b1;
    lat = 10;
    bus.weight_0 = 7'd9;
    push_job(2'b01, 7'd9, 1'b1);
    bus.req = 2'b01;
    wait_start("t4_start");
    bus.req = 2'b00;
    stale_mode = 1'b0;
    @(negedge clk);
    chk("t4_no_early_read", 64'(bus.mult_rd_dout), 64'd0);
    c = 1;
    while (!bus.out_valid && c < 2000) begin @(negedge clk); c++; end
    chk("t4_first_word_latency", 64'(c), 64'd13);
    wait_done("t4_done");

    // Multiplier never completes.
    lat = 0;
    bus.weight_0 = 7'd3;
    push_job(2'b01, 7'd3, 1'b0);
    bus.req = 2'b01;
    wait_start("t5_start");
    bus.req = 2'b00;
    c = 0;
    while (!bus.timeout_err && c < 2000) begin @(negedge clk); c++; end
    chk("t5_timeout_cycle", 64'(c), 64'(TIMEOUT + 1));
    chk("t5_timeout_grant", 64'(bus.grant), 64'd0);
    chk("t5_timeout_rd", 64'(bus.mult_rd_dout), 64'd0);
    repeat (5) @(negedge clk);
    chk("t5_timeout_sticky", 64'(bus.timeout_err), 64'd1);

    // Reset during readout of word 100, then a fresh job.
    lat = 30;
    bus.weight_1 = 7'd44;
    push_job(2'b10, 7'd44, 1'b1);
    bus.req = 2'b10;
    wait_start("t6_start");
    bus.req = 2'b00;
    hs0 = hs_cnt;
    c = 0;
    while (hs_cnt - hs0 < 100 && c < 5000) begin @(negedge clk); c++; end
    chk("t6_reached_word100", 64'(hs_cnt - hs0), 64'd100);
    chk("t6_terr_before_rst", 64'(bus.timeout_err), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    word_q.delete();
    done_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midjob_reset");
    @(posedge clk); #1 rst = 1'b0;
    lat = 15;
    bus.weight_0 = 7'd77;
    push_job(2'b01, 7'd77, 1'b1);
    bus.req = 2'b01;
    wait_start("t6_restart");
    bus.req = 2'b00;
    chk("t6_terr_cleared", 64'(bus.timeout_err), 64'd0);
    wait_done("t6_done");

    repeat (5) @(negedge clk);
    chk("end_words_left", 64'(word_q.size()), 64'd0);
    chk("end_starts_left", 64'(start_q.size()), 64'd0);
    chk("end_dones_left", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
